// File: rtl/pipeline_elastic_if.sv
// Handshake bundle for pipeline_elastic: upstream valid/ready, downstream
// valid/ready and the occupancy count. The slave modport is the pipeline's
// view; the master modport is the surrounding producer/consumer view.
interface pipeline_elastic_if #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 2
);
    localparam int CW = $clog2(DEPTH + 3);

    logic [DATAWIDTH-1:0] data_in_i;
    logic                 data_in_valid_i;
    logic                 data_in_ready_o;
    logic [DATAWIDTH-1:0] data_out_o;
    logic                 data_out_valid_o;
    logic                 data_out_ready_i;
    logic [CW-1:0]        count_o;

    modport slave (
        input  data_in_i,
        input  data_in_valid_i,
        output data_in_ready_o,
        output data_out_o,
        output data_out_valid_o,
        input  data_out_ready_i,
        output count_o
    );

    modport master (
        output data_in_i,
        output data_in_valid_i,
        input  data_in_ready_o,
        input  data_out_o,
        input  data_out_valid_o,
        output data_out_ready_i,
        input  count_o
    );
endinterface

// File: rtl/pipeline_elastic.sv
// pipeline_elastic: DEPTH chained valid/ready register stages with bubble
// collapsing, synchronous clear and an occupancy count.
// Optional macro PIPELINE_ELASTIC_SKID_EN puts a 2-entry skid buffer in front
// of stage 0 so that data_in_ready_o comes straight from a flop.
module pipeline_elastic #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              clear_i,
    pipeline_elastic_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 3);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipeline_elastic: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0][DATAWIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0]                rdy;
    logic [DEPTH-1:0][DATAWIDTH-1:0] stage_src_data;
    logic [DEPTH-1:0]                stage_src_valid;
    logic [CW-1:0]                   count_q, count_d;
    logic [CW-1:0]                   extra_cnt;
    logic                            src_valid;
    logic [DATAWIDTH-1:0]            src_data;
    logic                            in_fire;

`ifdef PIPELINE_ELASTIC_SKID_EN
    logic [1:0][DATAWIDTH-1:0] skid_data_q, skid_data_d;
    logic [1:0]                skid_cnt_q, skid_cnt_d;
    logic                      in_ready_q, in_ready_d;

    // Input side sees only the registered "skid not full" flag; a word offered
    // during clear is dropped rather than stored.
    assign bus.data_in_ready_o = in_ready_q;
    assign in_fire             = bus.data_in_valid_i & in_ready_q & ~clear_i;
    assign src_valid           = (skid_cnt_q != 2'd0);
    assign src_data            = skid_data_q[0];
    assign extra_cnt           = CW'(skid_cnt_d);

    // Skid FIFO next state: entry 0 is the head; pop into stage 0 and push from input may coincide
    always_comb begin
        skid_data_d = skid_data_q;
        skid_cnt_d  = skid_cnt_q;
        if (clear_i) begin
            skid_cnt_d = 2'd0;
        end else begin
            if (src_valid && rdy[0]) begin
                skid_data_d[0] = skid_data_q[1];
                skid_cnt_d     = skid_cnt_q - 2'd1;
            end
            if (in_fire) begin
                // in_ready_q guarantees fewer than two entries remain after the pop
                skid_data_d[skid_cnt_d[0]] = bus.data_in_i;
                skid_cnt_d                 = skid_cnt_d + 2'd1;
            end
        end
        in_ready_d = (skid_cnt_d != 2'd2);
    end

    // Skid registers and the registered input-ready flag
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            skid_data_q <= '0;
            skid_cnt_q  <= 2'd0;
            in_ready_q  <= 1'b0;
        end else begin
            skid_data_q <= skid_data_d;
            skid_cnt_q  <= skid_cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end
`else
    assign bus.data_in_ready_o = rdy[0] & arst_ni & ~clear_i;
    assign in_fire             = bus.data_in_valid_i & bus.data_in_ready_o;
    assign src_valid           = in_fire;
    assign src_data            = bus.data_in_i;
    assign extra_cnt           = '0;
`endif

    // Stage k may load when it or any stage after it is empty, or the output drains
    always_comb begin
        logic acc;
        acc = bus.data_out_ready_i;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = acc | ~valid_q[k];
            rdy[k] = acc;
        end
    end

    // Source of each stage: stage 0 from the input (or skid head), others from the previous stage
    always_comb begin
        stage_src_valid    = '0;
        stage_src_data     = '0;
        stage_src_valid[0] = src_valid;
        stage_src_data[0]  = src_data;
        for (int k = 1; k < DEPTH; k++) begin
            stage_src_valid[k] = valid_q[k-1];
            stage_src_data[k]  = data_q[k-1];
        end
    end

    // Stage next state; clear drops all valids but leaves data registers alone
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_d[k] = stage_src_valid[k];
                    if (stage_src_valid[k]) begin
                        data_d[k] = stage_src_data[k];
                    end
                end
            end
        end
    end

    // Occupancy after this edge: valid stages plus skid entries
    always_comb begin
        count_d = extra_cnt;
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CW'(valid_d[k]);
        end
    end

    // Stage and count registers
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            data_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.data_out_o       = data_q[DEPTH-1];
    assign bus.data_out_valid_o = valid_q[DEPTH-1];
    assign bus.count_o          = count_q;
endmodule

// File: tb/tb_pipeline_elastic.sv
module tb_pipeline_elastic;
    localparam int W  = 32;
    localparam int D  = 2;
    localparam int D4 = 4;
`ifdef PIPELINE_ELASTIC_SKID_EN
    localparam int EXTRA = 1;
    localparam int SKID  = 2;
`else
    localparam int EXTRA = 0;
    localparam int SKID  = 0;
`endif
    localparam int CAP = D + SKID;
    localparam int LAT = D + EXTRA;

    logic clk = 1'b0;
    logic arst_n;
    logic clear;
    logic clear4;

    always #5 clk = ~clk;

    pipeline_elastic_if #(.DATAWIDTH(W), .DEPTH(D))  bus  ();
    pipeline_elastic_if #(.DATAWIDTH(W), .DEPTH(D4)) bus4 ();

    pipeline_elastic #(.DATAWIDTH(W), .DEPTH(D)) dut (
        .clk_i  (clk),
        .arst_ni(arst_n),
        .clear_i(clear),
        .bus    (bus)
    );

    pipeline_elastic #(.DATAWIDTH(W), .DEPTH(D4)) dut4 (
        .clk_i  (clk),
        .arst_ni(arst_n),
        .clear_i(clear4),
        .bus    (bus4)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_deliv = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input agent: every accepted word is expected later, in order; clear/reset discard all.
    always @(posedge clk) begin
        if (!arst_n || clear) begin
            exp_q.delete();
        end else if (bus.data_in_valid_i && bus.data_in_ready_o) begin
            exp_q.push_back(bus.data_in_i);
        end
    end

    // Monitor: occupancy, ready and delivered data against the queue model.
    always @(negedge clk) begin
        if (arst_n) begin
            chk("count", bus.count_o, exp_q.size());
`ifndef PIPELINE_ELASTIC_SKID_EN
            chk("in_ready", bus.data_in_ready_o,
                (!clear && (exp_q.size() < D || bus.data_out_ready_i)) ? 1 : 0);
`endif
            if (exp_q.size() == 0) begin
                chk("idle_valid", bus.data_out_valid_o, 0);
            end else if (bus.data_out_valid_o && bus.data_out_ready_i && !clear) begin
                chk("data", bus.data_out_o, exp_q.pop_front());
                n_deliv++;
            end
        end
    end

    initial begin
        logic [W-1:0] words [4];
        int i;
        int start;
        int cyc;
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h4; words[3] = 32'h8;

        arst_n = 1'b0; clear = 1'b0; clear4 = 1'b0;
        bus.data_in_i = '0; bus.data_in_valid_i = 1'b0; bus.data_out_ready_i = 1'b0;
        bus4.data_in_i = '0; bus4.data_in_valid_i = 1'b0; bus4.data_out_ready_i = 1'b0;

        // Reset
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", bus.data_in_ready_o, 0);
        end
        @(posedge clk); #1;
        arst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rel_in_ready", bus.data_in_ready_o, 1);
        chk("rel_out_valid", bus.data_out_valid_o, 0);
        chk("rel_count", bus.count_o, 0);
        chk("rel_out_data", bus.data_out_o, 0);

        // Streaming with downstream always ready
        tick();
        bus.data_out_ready_i = 1'b1;
        for (int j = 0; j < LAT + 7; j++) begin
            bus.data_in_valid_i = (j < 4);
            bus.data_in_i = (j < 4) ? words[j] : '0;
            @(negedge clk);
            chk($sformatf("stream_valid_c%0d", j), bus.data_out_valid_o,
                (j >= LAT && j < LAT + 4) ? 1 : 0);
            if (j >= LAT && j < LAT + 4)
                chk($sformatf("stream_data_c%0d", j), bus.data_out_o, words[j-LAT]);
            if (j >= LAT && j <= LAT + 2)
                chk($sformatf("stream_count_c%0d", j), bus.count_o, LAT);
            tick();
        end
        bus.data_in_valid_i = 1'b0;

        // Backpressure: fill to capacity, next word must be refused
        bus.data_out_ready_i = 1'b0;
        start = n_deliv;
        i = 0;
        for (cyc = 0; cyc < CAP + 10; cyc++) begin
            bus.data_in_valid_i = 1'b1;
            bus.data_in_i = 32'hA + i;
            @(negedge clk);
            if (i == CAP) begin
                chk("bp_blocked_ready", bus.data_in_ready_o, 0);
                chk("bp_count", bus.count_o, CAP);
                break;
            end
            if (bus.data_in_ready_o) i++;
            tick();
        end
        chk("bp_accepted", i, CAP);
        tick();
        bus.data_out_ready_i = 1'b1;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.data_in_ready_o) break;
            tick();
        end
        tick();
        bus.data_in_valid_i = 1'b0;
        for (cyc = 0; cyc < 20 && (n_deliv - start) < CAP + 1; cyc++) tick();
        chk("bp_delivered", n_deliv - start, CAP + 1);

        // Clear with two words held and a word offered during the clear
        bus.data_out_ready_i = 1'b0;
        bus.data_in_valid_i = 1'b1; bus.data_in_i = 32'h31; tick();
        bus.data_in_i = 32'h32; tick();
        bus.data_in_valid_i = 1'b0;
        for (cyc = 0; cyc < 10 && bus.count_o != 2; cyc++) tick();
        chk("clr_pre_count", bus.count_o, 2);
        clear = 1'b1; bus.data_in_valid_i = 1'b1; bus.data_in_i = 32'h55;
        tick();
        clear = 1'b0; bus.data_in_valid_i = 1'b0;
        @(negedge clk);
        chk("clr_count", bus.count_o, 0);
        chk("clr_out_valid", bus.data_out_valid_o, 0);
        tick();
        bus.data_out_ready_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("clr_no_0x55_c%0d", j), bus.data_out_valid_o, 0);
            tick();
        end

        // Bubble collapse on the 4-stage instance
        bus4.data_out_ready_i = 1'b0;
        bus4.data_in_valid_i = 1'b1; bus4.data_in_i = 32'h10;
        tick();
        bus4.data_in_valid_i = 1'b0;
        repeat (D4 + EXTRA + 2) tick();
        @(negedge clk);
        chk("bub_out_valid", bus4.data_out_valid_o, 1);
        chk("bub_out_data", bus4.data_out_o, 32'h10);
        chk("bub_count1", bus4.count_o, 1);
        tick();
        bus4.data_in_valid_i = 1'b1; bus4.data_in_i = 32'h20;
        @(negedge clk);
        chk("bub_in_ready", bus4.data_in_ready_o, 1);
        tick();
        bus4.data_in_valid_i = 1'b0;
        @(negedge clk);
        chk("bub_count2", bus4.count_o, 2);
        chk("bub_out_hold", bus4.data_out_o, 32'h10);

        // Random traffic with occasional clear and one mid-stream reset
        tick();
        for (int j = 0; j < 10000; j++) begin
            clear = ($urandom_range(99) < 5);
            bus.data_in_valid_i = $urandom_range(1);
            bus.data_in_i = $urandom;
            bus.data_out_ready_i = $urandom_range(1);
            arst_n = !(j == 5000 || j == 5001);
            tick();
        end
        clear = 1'b0; arst_n = 1'b1;
        bus.data_in_valid_i = 1'b0; bus.data_out_ready_i = 1'b1;
        repeat (CAP + 6) tick();
        @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_count", bus.count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
